seq_bin16_to_bcd: RTL and testbench

Sequential binary-to-decimal converter between the CPU result register and the seven-segment digit decoder. Takes a 16-bit result on a start strobe and converts it with an iterative shift-and-add-3 (double dabble) loop, one bit per clock. Presents a sign flag plus five registered BCD digits that stay stable between conversions, so the display never flickers mid-conversion. Replaces the wide combinational divider chain with a small multi-cycle datapath.

---
 rtl/seq_bin16_to_bcd_pkg.sv | 13 +
 rtl/seq_bin16_to_bcd_add3.sv | 12 +
 rtl/seq_bin16_to_bcd.sv | 112 +++++++++++
 tb/tb_seq_bin16_to_bcd.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/seq_bin16_to_bcd_pkg.sv
// Shared constants and state encoding for the sequential binary-to-BCD converter.
package seq_bin16_to_bcd_pkg;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_t;

  localparam int NUM_DIGITS = 5;
  localparam int BCD_W      = 20;
  localparam int ITER       = 16;

endpackage

// File: rtl/seq_bin16_to_bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/seq_bin16_to_bcd.sv
// Multi-cycle binary-to-BCD converter: one double-dabble iteration per clock,
// results held in output registers that only update on completion.
//
// state      | meaning
// ST_IDLE    | waiting for start; outputs hold the last result
// ST_CONVERT | shifting one magnitude bit per clock into the BCD register
module seq_bin16_to_bcd #(
  parameter int SIGNED = 1,
  parameter int WIDTH  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             negative,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       digit4
);

  import seq_bin16_to_bcd_pkg::*;

  localparam int CNT_W = $clog2(ITER + 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   mag_r;
  logic [BCD_W-1:0]   bcd_r;
  logic [CNT_W-1:0]   count;
  logic               sign_r;
  logic               done_r;
  logic               negative_r;
  logic [BCD_W-1:0]   digits_r;

  logic               sign_in;
  logic [WIDTH-1:0]   mag_in;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic [WIDTH-1:0]   mag_shift;
  logic               last_iter;

  // 0x8000 negates to itself, which is exactly the unsigned magnitude 32768.
  assign sign_in = (SIGNED != 0) ? value[WIDTH-1] : 1'b0;
  assign mag_in  = sign_in ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_r[4*gi +: 4]),
      .dout (bcd_adj[4*gi +: 4])
    );
  end

  assign bcd_shift = {bcd_adj[BCD_W-2:0], mag_r[WIDTH-1]};
  assign mag_shift = {mag_r[WIDTH-2:0], 1'b0};
  assign last_iter = (state == ST_CONVERT) && (count == CNT_W'(ITER - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_CONVERT;
      ST_CONVERT: if (last_iter) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mag_r      <= '0;
      bcd_r      <= '0;
      count      <= '0;
      sign_r     <= 1'b0;
      done_r     <= 1'b0;
      negative_r <= 1'b0;
      digits_r   <= '0;
    end else if (state == ST_IDLE) begin
      done_r <= 1'b0;
      if (start) begin
        sign_r <= sign_in;
        mag_r  <= mag_in;
        bcd_r  <= '0;
        count  <= '0;
      end
    end else begin
      bcd_r  <= bcd_shift;
      mag_r  <= mag_shift;
      count  <= count + CNT_W'(1);
      done_r <= last_iter;
      if (last_iter) begin
        digits_r   <= bcd_shift;
        negative_r <= sign_r;
      end
    end
  end

  assign busy     = (state == ST_CONVERT);
  assign done     = done_r;
  assign negative = negative_r;
  assign digit0   = digits_r[3:0];
  assign digit1   = digits_r[7:4];
  assign digit2   = digits_r[11:8];
  assign digit3   = digits_r[15:12];
  assign digit4   = digits_r[19:16];

endmodule

// File: tb/tb_seq_bin16_to_bcd.sv
// Randomized self-checking bench: a signed and an unsigned converter share stimulus
// and are compared against a divide/modulo decimal reference.
module tb_seq_bin16_to_bcd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] value = '0;

  logic        busy_s, done_s, neg_s;
  logic [3:0]  d0_s, d1_s, d2_s, d3_s, d4_s;
  logic        busy_u, done_u, neg_u;
  logic [3:0]  d0_u, d1_u, d2_u, d3_u, d4_u;

  int n_checks = 0;
  int n_errors = 0;
  int prev_s = 0;
  int prev_u = 0;

  always #5 clk = ~clk;

  seq_bin16_to_bcd #(.SIGNED(1), .WIDTH(16)) dut_s (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy_s), .done(done_s), .negative(neg_s),
    .digit0(d0_s), .digit1(d1_s), .digit2(d2_s), .digit3(d3_s), .digit4(d4_s)
  );

  seq_bin16_to_bcd #(.SIGNED(0), .WIDTH(16)) dut_u (
    .clk(clk), .reset(reset), .start(start), .value(value),
    .busy(busy_u), .done(done_u), .negative(neg_u),
    .digit0(d0_u), .digit1(d1_u), .digit2(d2_u), .digit3(d3_u), .digit4(d4_u)
  );

  wire [19:0] digits_s = {d4_s, d3_s, d2_s, d1_s, d0_s};
  wire [19:0] digits_u = {d4_u, d3_u, d2_u, d1_u, d0_u};

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Decimal digits of the magnitude, packed one digit per nibble.
  function automatic int ref_bcd(input logic [15:0] v, input bit sgn, output bit neg);
    int m, p, r;
    neg = sgn && v[15];
    m = neg ? (65536 - int'(v)) : int'(v);
    r = 0;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r |= ((m / p) % 10) << (4 * i);
      p *= 10;
    end
    return r;
  endfunction

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_conv(input logic [15:0] v, input int inj_at, input logic [15:0] inj_v);
    int  exp_s, exp_u, busy_cnt;
    bit  en_s, en_u, got;
    exp_s = ref_bcd(v, 1'b1, en_s);
    exp_u = ref_bcd(v, 1'b0, en_u);
    start = 1'b1;
    value = v;
    busy_cnt = 0;
    got = 1'b0;
    for (int j = 1; j <= 40 && !got; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start = 1'b0;
        chk("done_pulse_width", int'(done_s), 0);
        chk("hold_digits_s", int'(digits_s), prev_s);
        chk("hold_digits_u", int'(digits_u), prev_u);
      end
      if (j == inj_at) begin
        start = 1'b1;
        value = inj_v;
      end else if (j == inj_at + 1) begin
        start = 1'b0;
      end
      if (done_s) got = 1'b1;
      else if (busy_s) busy_cnt++;
    end
    start = 1'b0;
    chk("done_timeout", int'(got), 1);
    chk("busy_cycles", busy_cnt, 16);
    chk("busy_low_at_done", int'(busy_s), 0);
    chk("done_u", int'(done_u), 1);
    chk("digits_s", int'(digits_s), exp_s);
    chk("negative_s", int'(neg_s), int'(en_s));
    chk("digits_u", int'(digits_u), exp_u);
    chk("negative_u", int'(neg_u), 0);
    prev_s = exp_s;
    prev_u = exp_u;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_s | busy_u), 0);
    chk({tag, "_done"}, int'(done_s | done_u), 0);
    chk({tag, "_neg"}, int'(neg_s | neg_u), 0);
    chk({tag, "_digits_s"}, int'(digits_s), 0);
    chk({tag, "_digits_u"}, int'(digits_u), 0);
  endtask

  initial begin
    int done_seen;
    logic [15:0] rv;

    #1;
    chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_conv(16'd0, 0, 16'd0);
    @(negedge clk);
    chk("done_single", int'(done_s), 0);
    do_conv(16'd12345, 0, 16'd0);
    @(negedge clk);
    do_conv(16'hFFFF, 0, 16'd0);
    do_conv(16'h8000, 0, 16'd0);
    @(negedge clk);
    do_conv(16'h7FFF, 0, 16'd0);
    @(negedge clk);

    // Second start mid-conversion is ignored; then a back-to-back start on done.
    do_conv(16'd100, 5, 16'd999);
    do_conv(16'd999, 0, 16'd0);
    @(negedge clk);

    // Async reset during a conversion discards it.
    start = 1'b1;
    value = 16'd54321;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk_all_zero("async_reset");
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (done_s || done_u || busy_s) done_seen++;
    end
    chk("no_done_after_reset", done_seen, 0);
    prev_s = 0;
    prev_u = 0;
    do_conv(16'd7, 0, 16'd0);
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      rv = 16'($urandom_range(0, 65535));
      if (n % 6 == 0) rv = 16'($urandom_range(65526, 65535));
      do_conv(rv, ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : 0,
              16'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
